// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RISC-V core.
//   - RV32I major opcode constants
//   - ct_t        : control-transfer class of the instruction in EX
//   - hz_state_t  : sequencing FSM states used by hazard_ctrl
package core_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    CT_NONE   = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JAL    = 2'b10,
    CT_JALR   = 2'b11
  } ct_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk   : rising-edge clock
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over inc
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Decides each cycle whether pipeline registers advance, hold or flush,
// tracks data-memory wait time with a timeout FSM and keeps saturating
// stall/flush performance counters.
// Inputs : clk, reset (sync, active-high), ID source regs (id_rs1, id_rs2,
//          id_uses_rs2), EX info (ex_rd, ex_mem_read, ex_ctrl_transfer,
//          ex_branch_taken), MEM info (mem_access, dmem_ready).
// Outputs: pc_write, pc_sel, if_id_write/flush, id_ex_write/flush,
//          ex_mem_write, mem_wb_flush, mem_err (sticky), stall_cnt, flush_cnt.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_ctrl_transfer,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [WAIT_W-1:0] wait_inc;

  logic mem_stall, redirect, load_use, active;
  logic stall_evt, flush_evt;

  assign mem_stall = mem_access & ~dmem_ready;
  assign redirect  = (ex_ctrl_transfer == CT_JAL) | (ex_ctrl_transfer == CT_JALR) |
                     ((ex_ctrl_transfer == CT_BRANCH) & ex_branch_taken);
  // x0 can never carry a hazard; rs2 only matters when ID actually reads it.
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  assign active    = (state != ERR);
  assign wait_inc  = wait_cnt + 1'b1;
  assign mem_err   = (state == ERR);

  // Redirect is only taken when MEM is not holding the pipe; the frozen EX
  // instruction re-evaluates once the memory access completes.
  assign stall_evt = active & (mem_stall | (load_use & ~redirect));
  assign flush_evt = active & ~mem_stall & redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_flush = 1'b1;
        end else if (redirect) begin
          pc_sel      = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end

        // Release cycle falls through to the RUN rules above, so a
        // completing access costs no extra cycle.
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (state == RUN) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else if (wait_inc == TIMEOUT_V) begin
          state_nxt    = ERR;
          wait_cnt_nxt = wait_inc;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end

      default: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall_evt),
    .clr   (reset),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (flush_evt),
    .clr   (reset),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share all inputs: one with
// default parameters and one with MEM_TIMEOUT=4, CNT_W=2 for the timeout and
// saturation cases.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
  logic [1:0] ex_ctrl_transfer;

  logic        a_pc_write, a_pc_sel, a_if_id_write, a_if_id_flush;
  logic        a_id_ex_write, a_id_ex_flush, a_ex_mem_write, a_mem_wb_flush, a_mem_err;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic        b_pc_write, b_pc_sel, b_if_id_write, b_if_id_flush;
  logic        b_id_ex_write, b_id_ex_flush, b_ex_mem_write, b_mem_wb_flush, b_mem_err;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  // Control vector order: pc_write pc_sel if_id_write if_id_flush
  //                       id_ex_write id_ex_flush ex_mem_write mem_wb_flush
  localparam logic [7:0] C_DEF = 8'b1010_1010;
  localparam logic [7:0] C_LU  = 8'b0000_1110;
  localparam logic [7:0] C_RD  = 8'b1111_1110;
  localparam logic [7:0] C_MS  = 8'b0000_0001;
  localparam logic [7:0] C_ERR = 8'b0000_0000;

  logic [7:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_write, a_pc_sel, a_if_id_write, a_if_id_flush,
                  a_id_ex_write, a_id_ex_flush, a_ex_mem_write, a_mem_wb_flush};
  assign b_ctl = {b_pc_write, b_pc_sel, b_if_id_write, b_if_id_flush,
                  b_id_ex_write, b_id_ex_flush, b_ex_mem_write, b_mem_wb_flush};

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_ctrl_transfer(ex_ctrl_transfer), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(a_pc_write), .pc_sel(a_pc_sel),
    .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_write(a_id_ex_write), .id_ex_flush(a_id_ex_flush),
    .ex_mem_write(a_ex_mem_write), .mem_wb_flush(a_mem_wb_flush),
    .mem_err(a_mem_err), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_ctrl_transfer(ex_ctrl_transfer), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(b_pc_write), .pc_sel(b_pc_sel),
    .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_write(b_id_ex_write), .id_ex_flush(b_id_ex_flush),
    .ex_mem_write(b_ex_mem_write), .mem_wb_flush(b_mem_wb_flush),
    .mem_err(b_mem_err), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0;
    ex_ctrl_transfer = 2'b00; ex_branch_taken = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_ctl", a_ctl, C_DEF);
    chk("rst_err", a_mem_err, 0);
    chk("rst_stall", a_stall_cnt, 0);
    chk("rst_flush", a_flush_cnt, 0);

    // Load-use on rs1
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; #1;
    chk("lu_ctl", a_ctl, C_LU);
    tick();
    chk("lu_stall", a_stall_cnt, 1);
    idle();
    chk("lu_clear_ctl", a_ctl, C_DEF);
    tick();
    chk("lu_clear_stall", a_stall_cnt, 1);

    // x0 never a hazard
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("x0_ctl", a_ctl, C_DEF);
    tick();
    chk("x0_stall", a_stall_cnt, 1);

    // rs2 gating
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; #1;
    chk("rs2_unused_ctl", a_ctl, C_DEF);
    id_uses_rs2 = 1'b1; #1;
    chk("rs2_used_ctl", a_ctl, C_LU);
    tick();
    chk("rs2_used_stall", a_stall_cnt, 2);

    // Taken branch beats load-use
    ex_ctrl_transfer = 2'b01; ex_branch_taken = 1'b1; #1;
    chk("br_taken_ctl", a_ctl, C_RD);
    tick();
    chk("br_taken_flush", a_flush_cnt, 1);
    chk("br_taken_stall", a_stall_cnt, 2);
    ex_branch_taken = 1'b0; #1;
    chk("br_not_taken_ctl", a_ctl, C_LU);
    tick();
    chk("br_not_taken_flush", a_flush_cnt, 1);
    chk("br_not_taken_stall", a_stall_cnt, 3);
    idle();
    ex_ctrl_transfer = 2'b11; #1;
    chk("jalr_ctl", a_ctl, C_RD);
    tick();
    chk("jalr_flush", a_flush_cnt, 2);

    // Memory wait of 3 cycles with JAL frozen in EX
    idle();
    ex_ctrl_transfer = 2'b10; mem_access = 1'b1; dmem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mw_ctl%0d", i), a_ctl, C_MS);
      tick();
    end
    chk("mw_stall", a_stall_cnt, 6);
    chk("mw_flush_hold", a_flush_cnt, 2);
    dmem_ready = 1'b1; #1;
    chk("mw_release_ctl", a_ctl, C_RD);
    tick();
    chk("mw_release_flush", a_flush_cnt, 3);
    chk("mw_release_stall", a_stall_cnt, 6);
    chk("mw_err", a_mem_err, 0);
    // Wait counter must have cleared: 3 more stalls stay below timeout of 4
    idle();
    mem_access = 1'b1; dmem_ready = 1'b0; #1;
    tick(); tick(); tick();
    chk("mw_rerun_small_err", b_mem_err, 0);
    chk("mw_rerun_small_ctl", b_ctl, C_MS);

    // Timeout on the small instance
    idle();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_ctl%0d", i), b_ctl, C_MS);
      tick();
      chk($sformatf("to_err%0d", i), b_mem_err, (i == 4) ? 1 : 0);
    end
    chk("to_err_ctl", b_ctl, C_ERR);
    chk("to_big_no_err", a_mem_err, 0);
    dmem_ready = 1'b1; ex_ctrl_transfer = 2'b10; #1;
    chk("to_frozen_ctl", b_ctl, C_ERR);
    tick();
    chk("to_frozen_flush", b_flush_cnt, 0);
    chk("to_sticky_err", b_mem_err, 1);
    chk("to_big_flush", a_flush_cnt, 1);
    reset = 1'b1;
    tick();
    chk("to_rst_err", b_mem_err, 0);
    chk("to_rst_stall", b_stall_cnt, 0);
    chk("to_rst_flush", b_flush_cnt, 0);
    reset = 1'b0;
    idle();
    chk("to_rst_ctl", b_ctl, C_DEF);

    // Saturation: 5 consecutive redirects on a 2-bit counter
    ex_ctrl_transfer = 2'b10; #1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat_small%0d", i), b_flush_cnt, (i > 3) ? 3 : i);
      chk($sformatf("sat_big%0d", i), a_flush_cnt, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Decides per cycle whether each pipeline register advances, holds or is flushed. Causes: load-use hazards, control transfers resolved in EX, and multi-cycle data-memory accesses in MEM.
- Tracks memory-wait duration with a timeout FSM.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- MEM_TIMEOUT, 16: max consecutive dmem wait cycles before the error state.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, STORE, BRANCH)
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a LOAD
- ex_ctrl_transfer  in  2  00 none, 01 branch, 10 JAL, 11 JALR
- ex_branch_taken  in  1  branch condition true (valid only when ex_ctrl_transfer=01)
- mem_access  in  1  MEM instruction has mem_read or mem_write set
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register loads next value
- pc_sel  out  1  1 selects the EX redirect target
- if_id_write  out  1  IF/ID register advances
- if_id_flush  out  1  IF/ID loaded with a bubble
- id_ex_write  out  1  ID/EX advances
- id_ex_flush  out  1  ID/EX loaded with a bubble
- ex_mem_write  out  1  EX/MEM advances
- mem_wb_flush  out  1  MEM/WB loaded with a bubble
- mem_err  out  1  sticky timeout error
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset → RUN. Wait counter cleared to 0, mem_err=0, both counters cleared to 0.
- Combinational terms:
  - mem_stall = mem_access & ~dmem_ready
  - redirect = (ex_ctrl_transfer==10) | (ex_ctrl_transfer==11) | (ex_ctrl_transfer==01 & ex_branch_taken)
  - load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))
- Default outputs (no hazard): all *_write=1, all flushes=0, pc_sel=0.
- Priority in RUN/MEM_WAIT: mem_stall > redirect > load_use.
- mem_stall:
  - pc_write, if_id_write, id_ex_write, ex_mem_write all 0; mem_wb_flush=1.
  - Redirect and load_use are suppressed; the frozen EX instruction re-evaluates after release.
- redirect, no mem_stall:
  - pc_sel=1, pc_write=1, if_id_flush=1, id_ex_flush=1.
  - load_use is ignored because the ID instruction is wrong-path.
- load_use only:
  - pc_write=0, if_id_write=0, id_ex_flush=1; exactly one bubble per hazard.
- FSM transitions:
  - RUN → MEM_WAIT when mem_stall; wait counter set to 1.
  - MEM_WAIT with mem_stall: counter increments. When the counter reaches MEM_TIMEOUT while mem_stall is still high → ERR.
  - MEM_WAIT without mem_stall (dmem_ready=1 or mem_access dropped): → RUN, counter cleared. That cycle uses RUN output rules, so an access completes with zero extra latency.
- ERR:
  - mem_err=1; all *_write=0, all flushes=0, pc_sel=0; counters frozen.
  - Exits only via reset.
- Counters:
  - stall_cnt += 1 on every cycle with mem_stall or (load_use without redirect), in RUN/MEM_WAIT.
  - flush_cnt += 1 on every redirect cycle.
  - Both saturate at all-ones, with no wrap.
- Reset asserted mid-wait or in ERR: next cycle is RUN with all state cleared. reset has priority over every other input.
- x0 is never a hazard source. ex_rd=0 with ex_mem_read=1 produces no stall.

Decomposition:
- Shared package (core_pkg):
  - opcode constants: OP, OP_IMM, JAL, JALR, BRANCH, LOAD, STORE
  - ctrl_transfer enum: CT_NONE=00, CT_BRANCH=01, CT_JAL=10, CT_JALR=11
  - FSM state enum (hz_state_t)
- Sub-module sat_counter (parameter W; inputs inc, clr; output count): instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1; next cycle with ex_mem_read=0, defaults restored.
- x0 and rs2 gating:
  - ex_rd=0, id_rs1=0, ex_mem_read=1 → no stall.
  - ex_rd=7, id_rs2=7, id_uses_rs2=0 → no stall.
  - ex_rd=7, id_rs2=7, id_uses_rs2=1 → stall.
- Redirect beats load-use: ex_ctrl_transfer=01, ex_branch_taken=1 while load_use is true → pc_sel=1, if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt unchanged. Repeat with ex_branch_taken=0 → no redirect.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 → 3 cycles of all writes 0 and mem_wb_flush=1, JAL in EX ignored; the 4th cycle asserts redirect; stall_cnt=3, FSM back in RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → mem_err=1 after the 4th wait cycle; outputs frozen thereafter even once dmem_ready=1; reset=1 for one cycle → RUN, mem_err=0, both counters 0.
- Saturation: CNT_W=2, 5 consecutive redirects → flush_cnt sequence 1,2,3,3,3.
